// File: rtl/lu_sweep_driver.sv
// Built-in self-test initiator for a 2-input logic unit: sweeps all 16
// {select_g, select, a, b} vectors, compares s_in to the golden function, reports mismatches.
module lu_sweep_driver #(
   parameter int SETTLE = 1,
   parameter int ERR_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             select,
   output logic             select_g,
   input  logic             s_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [15:0]      fail_vec,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_idx, w_idx_nxt;
   logic [3:0]       r_cnt, w_cnt_nxt;
   logic [3:0]       r_vec, w_vec_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_pass, w_pass_nxt;
   logic [ERR_W-1:0] r_err, w_err_nxt;
   logic [15:0]      r_fail, w_fail_nxt;

   logic             w_sample;
   logic             w_exp;
   logic             w_miss;
   logic [ERR_W-1:0] w_err_sat;

   // idx = {select_g, select, a, b}; select inverts, select_g picks OR over AND
   assign w_exp     = (r_idx[3] ? (r_idx[1] | r_idx[0]) : (r_idx[1] & r_idx[0])) ^ r_idx[2];
   assign w_sample  = (r_cnt == 4'(SETTLE));
   assign w_miss    = w_sample && (s_in != w_exp);
   assign w_err_sat = (r_err == {ERR_W{1'b1}}) ? r_err : r_err + ERR_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_vec_nxt   = 4'd0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = r_pass;
      w_err_nxt   = r_err;
      w_fail_nxt  = r_fail;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_APPLY;
               w_idx_nxt   = 4'd0;
               w_cnt_nxt   = 4'd0;
               w_busy_nxt  = 1'b1;
               w_err_nxt   = '0;
               w_fail_nxt  = 16'd0;
               w_pass_nxt  = 1'b0;
            end
         end
         ST_APPLY: begin
            w_busy_nxt = 1'b1;
            w_vec_nxt  = r_idx;
            if (w_sample) begin
               if (w_miss) begin
                  w_fail_nxt = r_fail | (16'd1 << r_idx);
                  w_err_nxt  = w_err_sat;
               end
               if (r_idx != 4'd15) begin
                  w_idx_nxt = r_idx + 4'd1;
                  w_cnt_nxt = 4'd0;
                  w_vec_nxt = r_idx + 4'd1;
               end else begin
                  w_state_nxt = ST_FIN;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_vec_nxt   = 4'd0;
                  // include the final vector's result in the verdict
                  w_pass_nxt  = (w_err_nxt == '0);
               end
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         ST_FIN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= 4'd0;
         r_cnt   <= 4'd0;
         r_vec   <= 4'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
         r_fail  <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_vec   <= w_vec_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_pass  <= w_pass_nxt;
         r_err   <= w_err_nxt;
         r_fail  <= w_fail_nxt;
      end
   end

   assign select_g    = r_vec[3];
   assign select      = r_vec[2];
   assign a           = r_vec[1];
   assign b           = r_vec[0];
   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign err_count   = r_err;
   assign fail_vec    = r_fail;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lu_sweep_driver.sv
// Directed bench for lu_sweep_driver: three instances (SETTLE=1, SETTLE=0,
// ERR_W=2) each driving a behavioural LU with selectable fault modes.
module tb_lu_sweep_driver;

   logic clk = 1'b0;
   logic rst_n;
   logic start_v [3];
   int   mode_v  [3];

   logic        busy_v [3];
   logic        done_v [3];
   logic        pass_v [3];
   logic [4:0]  err_v  [3];
   logic [15:0] fail_v [3];
   logic [3:0]  vec_v  [3];
   logic [1:0]  st_v   [3];
   logic        s_v    [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // mode 0: correct LU, 1: inverted at idx 5, 2: stuck at 0, 3: stuck at 1
   function automatic logic lu_model(input logic [3:0] v, input int mode);
      logic g;
      case (v[3:2])
         2'b00:   g = v[1] & v[0];
         2'b01:   g = ~(v[1] & v[0]);
         2'b10:   g = v[1] | v[0];
         default: g = ~(v[1] | v[0]);
      endcase
      if (mode == 1 && v == 4'd5) g = ~g;
      if (mode == 2) g = 1'b0;
      if (mode == 3) g = 1'b1;
      return g;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int ST = (g == 1) ? 0 : 1;
      localparam int EW = (g == 2) ? 2 : 5;
      logic          w_a, w_b, w_sel, w_selg;
      logic [EW-1:0] w_ec;
      lu_sweep_driver #(.SETTLE(ST), .ERR_W(EW)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start_v[g]),
         .a           (w_a),
         .b           (w_b),
         .select      (w_sel),
         .select_g    (w_selg),
         .s_in        (s_v[g]),
         .busy        (busy_v[g]),
         .done        (done_v[g]),
         .pass        (pass_v[g]),
         .err_count   (w_ec),
         .fail_vec    (fail_v[g]),
         .o_dbg_state (st_v[g])
      );
      assign vec_v[g] = {w_selg, w_sel, w_a, w_b};
      assign err_v[g] = 5'(w_ec);
      assign s_v[g]   = lu_model(vec_v[g], mode_v[g]);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input int d, input string tag);
      check({tag, "_busy"}, 32'(busy_v[d]), 0);
      check({tag, "_done"}, 32'(done_v[d]), 0);
      check({tag, "_vec"},  32'(vec_v[d]), 0);
   endtask

   // Start pulse, then per-cycle order/hold checks, then the done pulse.
   task automatic run_sweep(input int d, input int hold, input bit poke);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      for (int c = 0; c < 16 * hold; c++) begin
         check("run_busy", 32'(busy_v[d]), 1);
         check("run_vec", 32'(vec_v[d]), 32'(c / hold));
         check("run_done_early", 32'(done_v[d]), 0);
         start_v[d] = poke && (c == 4 || c == 5);
         @(negedge clk);
      end
      start_v[d] = 1'b0;
      check("fin_done", 32'(done_v[d]), 1);
      check("fin_busy", 32'(busy_v[d]), 0);
      check("fin_vec", 32'(vec_v[d]), 0);
      check("fin_state", 32'(st_v[d]), 2);
      @(negedge clk);
      check("post_done", 32'(done_v[d]), 0);
      check("post_state", 32'(st_v[d]), 0);
   endtask

   task automatic check_result(input int d, input int err, input int fail, input int ps);
      check("err_count", 32'(err_v[d]), 32'(err));
      check("fail_vec", 32'(fail_v[d]), 32'(fail));
      check("pass", 32'(pass_v[d]), 32'(ps));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b1;
         mode_v[i]  = 0;
      end
      // reset wins over start
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check_idle(i, "rst");
            check("rst_err", 32'(err_v[i]), 0);
            check("rst_fail", 32'(fail_v[i]), 0);
            check("rst_pass", 32'(pass_v[i]), 0);
         end
      end
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_idle(0, "rel");

      mode_v[0] = 0; run_sweep(0, 2, 1'b0); check_result(0, 0, 16'h0000, 1);
      mode_v[0] = 1; run_sweep(0, 2, 1'b0); check_result(0, 1, 16'h0020, 0);
      mode_v[0] = 2; run_sweep(0, 2, 1'b0); check_result(0, 8, 16'h1E78, 0);
      mode_v[0] = 3; run_sweep(0, 2, 1'b0); check_result(0, 8, 16'hE187, 0);

      // start during APPLY is ignored: exactly one done, results held afterwards
      mode_v[0] = 0; run_sweep(0, 2, 1'b1);
      for (int k = 0; k < 4; k++) begin
         check_idle(0, "after_poke");
         check_result(0, 0, 16'h0000, 1);
         @(negedge clk);
      end

      // reset while vector 7 is applied
      mode_v[0] = 3;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (14) @(negedge clk);
      check("mid_vec", 32'(vec_v[0]), 7);
      check("mid_busy", 32'(busy_v[0]), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_idle(0, "midrst");
      check_result(0, 0, 16'h0000, 0);
      check("midrst_state", 32'(st_v[0]), 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("midrst_no_done", 32'(done_v[0]), 0);
      end
      mode_v[0] = 0; run_sweep(0, 2, 1'b0); check_result(0, 0, 16'h0000, 1);

      // SETTLE=0: one cycle per vector, done 16 cycles after start
      mode_v[1] = 0; run_sweep(1, 1, 1'b0); check_result(1, 0, 16'h0000, 1);
      mode_v[1] = 1; run_sweep(1, 1, 1'b0); check_result(1, 1, 16'h0020, 0);

      // ERR_W=2 saturates at 3
      mode_v[2] = 2; run_sweep(2, 2, 1'b0); check_result(2, 3, 16'h1E78, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
